// File: rtl/decode_issue_ctrl_pkg.sv
// Shared RV32I decode constants and ID-stage bundles.
// Imported by the decode table and the issue controller.
package decode_issue_ctrl_pkg;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] OP     = 7'b0110011;

    // Must match the immediate extender's select encoding bit for bit.
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    typedef enum logic {
        ST_RUN,
        ST_BUBBLE
    } state_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       alu_src;
        logic       imm_upper;
        logic       illegal;
        logic       rs1_used;
        logic       rs2_used;
        logic [1:0] imm_en;
    } ctrl_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       alu_src;
        logic       imm_upper;
        logic       illegal;
        logic [1:0] imm_en;
    } id_ex_t;

endpackage

// File: rtl/decode_issue_ctrl_decode.sv
// Pure combinational RV32I opcode to control/immediate-format table.
// Unknown opcodes decode as illegal with no side effects.
module rv32i_ctrl_decode
    import decode_issue_ctrl_pkg::*;
(
    input  logic [6:0] op_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        unique case (1'b1)
            (op_i == OP_IMM): begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.rs1_used  = 1'b1;
                ctrl_o.imm_en    = IMM_I;
            end
            (op_i == LOAD): begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.rs1_used  = 1'b1;
                ctrl_o.imm_en    = IMM_I;
            end
            (op_i == JALR): begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.jump      = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.rs1_used  = 1'b1;
                ctrl_o.imm_en    = IMM_I;
            end
            (op_i == STORE): begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.rs1_used  = 1'b1;
                ctrl_o.rs2_used  = 1'b1;
                ctrl_o.imm_en    = IMM_S;
            end
            (op_i == BRANCH): begin
                ctrl_o.branch    = 1'b1;
                ctrl_o.rs1_used  = 1'b1;
                ctrl_o.rs2_used  = 1'b1;
                ctrl_o.imm_en    = IMM_B;
            end
            (op_i == JAL): begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.jump      = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.imm_en    = IMM_J;
            end
            (op_i == LUI),
            (op_i == AUIPC): begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.imm_upper = 1'b1;
            end
            (op_i == OP): begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.rs1_used  = 1'b1;
                ctrl_o.rs2_used  = 1'b1;
            end
            default: ctrl_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_issue_ctrl.sv
// RV32I decode-stage issue controller: ID/EX register, load-use
// bubble FSM, flush and EX back-pressure handling.
module decode_issue_ctrl
    import decode_issue_ctrl_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   if_valid,
    input  logic [31:0]            if_instr,
    output logic                   id_ready,
    input  logic                   flush,
    input  logic                   ex_ready,
    output logic [1:0]             imm_en,
    output logic                   ex_valid,
    output logic [4:0]             ex_rd,
    output logic [4:0]             ex_rs1,
    output logic [4:0]             ex_rs2,
    output logic                   ex_reg_write,
    output logic                   ex_mem_read,
    output logic                   ex_mem_write,
    output logic                   ex_branch,
    output logic                   ex_jump,
    output logic                   ex_alu_src,
    output logic                   ex_imm_upper,
    output logic [1:0]             ex_imm_en,
    output logic                   ex_illegal,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    ctrl_t                  dec;
    id_ex_t                 ex_q, ex_d;
    state_e                 state_q, state_d;
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]             rs1, rs2;
    logic                   hz, stall, issue, bubble;
    logic                   unused_bits;

    rv32i_ctrl_decode u_dec (
        .op_i   (if_instr[6:0]),
        .ctrl_o (dec)
    );

    assign unused_bits = ^{if_instr[31:25], if_instr[14:12]};

    // Unused source fields read as x0 so they can never match ex_rd.
    assign rs1 = dec.rs1_used ? if_instr[19:15] : 5'd0;
    assign rs2 = dec.rs2_used ? if_instr[24:20] : 5'd0;

    assign hz = if_valid & ex_q.valid & ex_q.mem_read &
                (ex_q.rd != 5'd0) &
                ((ex_q.rd == rs1) | (ex_q.rd == rs2));

    assign stall    = (state_q == ST_RUN) & hz;
    assign bubble   = flush | (ex_ready & stall);
    assign issue    = ~flush & ex_ready & ~stall;
    assign id_ready = flush | (ex_ready & ~stall);
    assign imm_en   = dec.imm_en;

    always_comb begin
        ex_d = ex_q;
        if (bubble) begin
            ex_d.valid     = 1'b0;
            ex_d.reg_write = 1'b0;
            ex_d.mem_read  = 1'b0;
            ex_d.mem_write = 1'b0;
        end else if (issue) begin
            ex_d.valid     = if_valid;
            ex_d.rd        = if_instr[11:7];
            ex_d.rs1       = rs1;
            ex_d.rs2       = rs2;
            ex_d.reg_write = dec.reg_write & if_valid;
            ex_d.mem_read  = dec.mem_read & if_valid;
            ex_d.mem_write = dec.mem_write & if_valid;
            ex_d.branch    = dec.branch;
            ex_d.jump      = dec.jump;
            ex_d.alu_src   = dec.alu_src;
            ex_d.imm_upper = dec.imm_upper;
            ex_d.illegal   = dec.illegal;
            ex_d.imm_en    = dec.imm_en;
        end
    end

    always_comb begin
        state_d = ST_RUN;
        if (!flush && !ex_ready) state_d = state_q;
        else if (!flush && stall) state_d = ST_BUBBLE;
    end

    // Saturating: a pegged counter stays at all-ones.
    assign cnt_d = (issue | flush | ~stall | (&cnt_q)) ? cnt_q :
                   cnt_q + STALL_CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= '0;
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            state_q <= state_d;
            cnt_q   <= (ex_ready & ~flush) ? cnt_d : cnt_q;
        end
    end

    assign ex_valid     = ex_q.valid;
    assign ex_rd        = ex_q.rd;
    assign ex_rs1       = ex_q.rs1;
    assign ex_rs2       = ex_q.rs2;
    assign ex_reg_write = ex_q.reg_write;
    assign ex_mem_read  = ex_q.mem_read;
    assign ex_mem_write = ex_q.mem_write;
    assign ex_branch    = ex_q.branch;
    assign ex_jump      = ex_q.jump;
    assign ex_alu_src   = ex_q.alu_src;
    assign ex_imm_upper = ex_q.imm_upper;
    assign ex_imm_en    = ex_q.imm_en;
    assign ex_illegal   = ex_q.illegal;
    assign stall_cnt    = cnt_q;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Table-driven scoreboard bench for decode_issue_ctrl.
// Counter width is reduced so saturation is reachable quickly.
module tb_decode_issue_ctrl;

    localparam int W = 3;

    localparam logic [31:0] I_ADDI  = 32'h0050_0093;
    localparam logic [31:0] I_SW    = 32'h0011_2223;
    localparam logic [31:0] I_BEQ   = 32'h0020_8063;
    localparam logic [31:0] I_JAL   = 32'h0000_00EF;
    localparam logic [31:0] I_LW3   = 32'h0000_A183;
    localparam logic [31:0] I_LW0   = 32'h0000_A003;
    localparam logic [31:0] I_ADD   = 32'h0051_8233;
    localparam logic [31:0] I_ADD05 = 32'h0050_0233;
    localparam logic [31:0] I_LUI   = 32'h1234_51B7;
    localparam logic [31:0] I_ILL   = 32'h0000_007F;

    // {reg_write, mem_read, mem_write, branch, jump, alu_src, imm_upper, illegal}
    localparam logic [7:0] C_ADDI = 8'b1000_0100;
    localparam logic [7:0] C_SW   = 8'b0010_0100;
    localparam logic [7:0] C_BEQ  = 8'b0001_0000;
    localparam logic [7:0] C_JAL  = 8'b1000_1100;
    localparam logic [7:0] C_LW   = 8'b1100_0100;
    localparam logic [7:0] C_ADD  = 8'b1000_0000;
    localparam logic [7:0] C_LUI  = 8'b1000_0110;
    localparam logic [7:0] C_ILL  = 8'b0000_0001;
    localparam logic [7:0] C_NONE = 8'b0000_0000;

    typedef struct {
        logic         v;
        logic [31:0]  ins;
        logic         fl;
        logic         rdy;
        logic         idr;
        logic [1:0]   imm;
        logic         ev;
        logic [4:0]   rd;
        logic [4:0]   rs1;
        logic [4:0]   rs2;
        logic [7:0]   ctl;
        logic [1:0]   eimm;
        logic [W-1:0] cnt;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         if_valid;
    logic [31:0]  if_instr;
    logic         id_ready;
    logic         flush;
    logic         ex_ready;
    logic [1:0]   imm_en;
    logic         ex_valid;
    logic [4:0]   ex_rd, ex_rs1, ex_rs2;
    logic         ex_reg_write, ex_mem_read, ex_mem_write;
    logic         ex_branch, ex_jump, ex_alu_src, ex_imm_upper;
    logic [1:0]   ex_imm_en;
    logic         ex_illegal;
    logic [W-1:0] stall_cnt;

    int   checks = 0;
    int   errors = 0;
    vec_t tbl[22];
    vec_t sb[$];

    always #5 clk = ~clk;

    decode_issue_ctrl #(.STALL_CNT_W(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .id_ready     (id_ready),
        .flush        (flush),
        .ex_ready     (ex_ready),
        .imm_en       (imm_en),
        .ex_valid     (ex_valid),
        .ex_rd        (ex_rd),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_branch    (ex_branch),
        .ex_jump      (ex_jump),
        .ex_alu_src   (ex_alu_src),
        .ex_imm_upper (ex_imm_upper),
        .ex_imm_en    (ex_imm_en),
        .ex_illegal   (ex_illegal),
        .stall_cnt    (stall_cnt)
    );

    function automatic logic [7:0] ctl_act();
        return {ex_reg_write, ex_mem_read, ex_mem_write, ex_branch,
                ex_jump, ex_alu_src, ex_imm_upper, ex_illegal};
    endfunction

    function automatic vec_t mk(
        logic v, logic [31:0] ins, logic fl, logic rdy,
        logic idr, logic [1:0] imm, logic ev,
        logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
        logic [7:0] ctl, logic [1:0] eimm, logic [W-1:0] cnt);
        vec_t t;
        t.v = v; t.ins = ins; t.fl = fl; t.rdy = rdy;
        t.idr = idr; t.imm = imm; t.ev = ev;
        t.rd = rd; t.rs1 = rs1; t.rs2 = rs2;
        t.ctl = ctl; t.eimm = eimm; t.cnt = cnt;
        return t;
    endfunction

    function automatic vec_t bub(logic [31:0] ins, logic fl, logic rdy,
                                 logic idr, logic [W-1:0] cnt);
        return mk(1'b1, ins, fl, rdy, idr, 2'd0, 1'b0,
                  5'd0, 5'd0, 5'd0, C_NONE, 2'd0, cnt);
    endfunction

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic pop_check(input string tag);
        vec_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s.sb: got empty expected entry", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, ".ex_valid"}, ex_valid, e.ev);
        chk({tag, ".stall_cnt"}, stall_cnt, e.cnt);
        chk({tag, ".rw_mr_mw"}, {ex_reg_write, ex_mem_read, ex_mem_write},
            e.ev ? e.ctl[7:5] : 3'b000);
        if (e.ev) begin
            chk({tag, ".ex_rd"}, ex_rd, e.rd);
            chk({tag, ".ex_rs1"}, ex_rs1, e.rs1);
            chk({tag, ".ex_rs2"}, ex_rs2, e.rs2);
            chk({tag, ".ctl"}, ctl_act(), e.ctl);
            chk({tag, ".ex_imm_en"}, ex_imm_en, e.eimm);
        end
    endtask

    task automatic apply(input vec_t t, input string tag);
        @(negedge clk);
        if_valid = t.v;
        if_instr = t.ins;
        flush    = t.fl;
        ex_ready = t.rdy;
        #1;
        chk({tag, ".id_ready"}, id_ready, t.idr);
        chk({tag, ".imm_en"}, imm_en, t.imm);
        sb.push_back(t);
        @(posedge clk);
        #1;
        pop_check(tag);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".ex_valid"}, ex_valid, 1'b0);
        chk({tag, ".ex_rd"}, ex_rd, 5'd0);
        chk({tag, ".ex_rs"}, {ex_rs1, ex_rs2}, 10'd0);
        chk({tag, ".ctl"}, ctl_act(), C_NONE);
        chk({tag, ".ex_imm_en"}, ex_imm_en, 2'd0);
        chk({tag, ".stall_cnt"}, stall_cnt, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] c;

        tbl[0]  = mk(1, I_ADDI, 0, 1, 1, 2'd0, 1, 5'd1, 5'd0, 5'd0, C_ADDI, 2'd0, 0);
        tbl[1]  = mk(1, I_SW,   0, 1, 1, 2'd1, 1, 5'd4, 5'd2, 5'd1, C_SW,   2'd1, 0);
        tbl[2]  = mk(1, I_BEQ,  0, 1, 1, 2'd2, 1, 5'd0, 5'd1, 5'd2, C_BEQ,  2'd2, 0);
        tbl[3]  = mk(1, I_JAL,  0, 1, 1, 2'd3, 1, 5'd1, 5'd0, 5'd0, C_JAL,  2'd3, 0);
        tbl[4]  = mk(1, I_LW3,  0, 1, 1, 2'd0, 1, 5'd3, 5'd1, 5'd0, C_LW,   2'd0, 0);
        tbl[5]  = bub(I_ADD, 0, 1, 0, 1);
        tbl[6]  = mk(1, I_ADD,  0, 1, 1, 2'd0, 1, 5'd4, 5'd3, 5'd5, C_ADD,  2'd0, 1);
        tbl[7]  = mk(1, I_LW0,  0, 1, 1, 2'd0, 1, 5'd0, 5'd1, 5'd0, C_LW,   2'd0, 1);
        tbl[8]  = mk(1, I_ADD05,0, 1, 1, 2'd0, 1, 5'd4, 5'd0, 5'd5, C_ADD,  2'd0, 1);
        tbl[9]  = mk(1, I_LW3,  0, 1, 1, 2'd0, 1, 5'd3, 5'd1, 5'd0, C_LW,   2'd0, 1);
        tbl[10] = mk(1, I_LUI,  0, 1, 1, 2'd0, 1, 5'd3, 5'd0, 5'd0, C_LUI,  2'd0, 1);
        tbl[11] = mk(1, I_LW3,  0, 1, 1, 2'd0, 1, 5'd3, 5'd1, 5'd0, C_LW,   2'd0, 1);
        tbl[12] = bub(I_ADD, 1, 1, 1, 1);
        tbl[13] = mk(1, I_LW3,  0, 1, 1, 2'd0, 1, 5'd3, 5'd1, 5'd0, C_LW,   2'd0, 1);
        tbl[14] = bub(I_ADD, 0, 1, 0, 2);
        tbl[15] = bub(I_ADD, 0, 0, 0, 2);
        tbl[16] = bub(I_ADD, 0, 0, 0, 2);
        tbl[17] = bub(I_ADD, 0, 0, 0, 2);
        tbl[18] = mk(1, I_ADD,  0, 1, 1, 2'd0, 1, 5'd4, 5'd3, 5'd5, C_ADD,  2'd0, 2);
        tbl[19] = mk(1, I_ILL,  0, 1, 1, 2'd0, 1, 5'd0, 5'd0, 5'd0, C_ILL,  2'd0, 2);
        tbl[20] = mk(1, I_ADDI, 0, 0, 0, 2'd0, 1, 5'd0, 5'd0, 5'd0, C_ILL,  2'd0, 2);
        tbl[21] = mk(0, I_ADDI, 0, 1, 1, 2'd0, 0, 5'd0, 5'd0, 5'd0, C_NONE, 2'd0, 2);

        rst_n    = 1'b0;
        if_valid = 1'b0;
        if_instr = 32'd0;
        flush    = 1'b0;
        ex_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++)
            apply(tbl[i], $sformatf("v%0d", i));

        apply(mk(1, I_LW3, 0, 1, 1, 2'd0, 1, 5'd3, 5'd1, 5'd0, C_LW, 2'd0, 2), "pre_rst_lw");
        apply(bub(I_ADD, 0, 1, 0, 3), "pre_rst_bub");
        #2;
        rst_n    = 1'b0;
        if_valid = 1'b0;
        #1;
        chk_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        c = 0;
        for (int i = 0; i < 9; i++) begin
            apply(mk(1, I_LW3, 0, 1, 1, 2'd0, 1, 5'd3, 5'd1, 5'd0, C_LW, 2'd0, c),
                  $sformatf("sat%0d_lw", i));
            c = (c == {W{1'b1}}) ? c : c + 1'b1;
            apply(bub(I_ADD, 0, 1, 0, c), $sformatf("sat%0d_bub", i));
            apply(mk(1, I_ADD, 0, 1, 1, 2'd0, 1, 5'd4, 5'd3, 5'd5, C_ADD, 2'd0, c),
                  $sformatf("sat%0d_add", i));
        end
        chk("sat_final", stall_cnt, {W{1'b1}});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
